traffic_seq: RTL and testbench

Sequential core of the traffic-light controller. It holds the light state register and the tick prescaler, times the dwell in each state, and applies the next-state rules with an asynchronous-input alert mode. It drives the lamp outputs directly. It sits between the board clock/reset, the alert switch, and the three lamp drivers.

---
 rtl/traffic_seq_pkg.sv | 27 ++
 rtl/traffic_seq_if.sv | 15 +
 rtl/traffic_seq_tick_gen.sv | 28 ++
 rtl/traffic_seq.sv | 110 +++++++++++
 tb/tb_traffic_seq.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/traffic_seq_pkg.sv
// Shared types for the traffic-light sequencer: light state encoding and
// dwell counter width, plus the lamp decode used by the top level.
package traffic_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10,
    RED    = 2'b11
  } light_state_e;

  localparam int DWELL_W = 8;

  // Lamp drives as {g, y, r}; OFF leaves every lamp dark.
  function automatic logic [2:0] lamps_of(input light_state_e st);
    logic [2:0] lamps;
    lamps = 3'b000;
    case (st)
      GREEN:   lamps = 3'b100;
      YELLOW:  lamps = 3'b010;
      RED:     lamps = 3'b001;
      default: lamps = 3'b000;
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/traffic_seq_if.sv
// Lamp/alert bundle between the sequencer (slave side) and its environment.
interface traffic_seq_if;
  import traffic_pkg::*;

  logic         alert;
  light_state_e state;
  logic         lamp_g;
  logic         lamp_y;
  logic         lamp_r;
  logic         tick;

  modport master (output alert, input state, lamp_g, lamp_y, lamp_r, tick);
  modport slave  (input alert, output state, lamp_g, lamp_y, lamp_r, tick);

endinterface

// File: rtl/traffic_seq_tick_gen.sv
// Free-running dwell prescaler: tick is high while the count sits at its
// last value, so TICK_DIV=1 yields a constant tick.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/traffic_seq.sv
// Traffic-light sequencer: alert synchronizer, dwell timing, next-state
// rules (normal cycle or blinking yellow) and lamp decode.
module traffic_seq
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int T_GREEN  = 5,
  parameter int T_YELLOW = 2,
  parameter int T_RED    = 5,
  parameter int T_BLINK  = 1
) (
  input  logic          clk,
  input  logic          reset,
  traffic_seq_if.slave  bus
);

  localparam logic [DWELL_W-1:0] LIM_G = DWELL_W'(T_GREEN - 1);
  localparam logic [DWELL_W-1:0] LIM_Y = DWELL_W'(T_YELLOW - 1);
  localparam logic [DWELL_W-1:0] LIM_R = DWELL_W'(T_RED - 1);
  localparam logic [DWELL_W-1:0] LIM_B = DWELL_W'(T_BLINK - 1);

  logic               w_tick;
  logic               r_sync1;
  logic               r_sync2;
  logic               w_alert_s;
  light_state_e       r_state;
  light_state_e       w_state_next;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] w_dwell_next;
  logic [DWELL_W-1:0] w_limit_m1;
  logic               w_expired;
  logic [2:0]         w_lamps;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.alert;
      r_sync2 <= r_sync1;
    end
  end

  assign w_alert_s = r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= GREEN;
      r_dwell <= '0;
    end else begin
      r_state <= w_state_next;
      r_dwell <= w_dwell_next;
    end
  end

  // Yellow shortens to the blink period whenever alert is active.
  always_comb begin
    w_limit_m1 = LIM_B;
    case (r_state)
      GREEN:   w_limit_m1 = LIM_G;
      RED:     w_limit_m1 = LIM_R;
      YELLOW:  w_limit_m1 = w_alert_s ? LIM_B : LIM_Y;
      default: w_limit_m1 = LIM_B;
    endcase
  end

  assign w_expired = w_tick && (r_dwell == w_limit_m1);

  always_comb begin
    w_state_next = r_state;
    w_dwell_next = r_dwell;
    w_lamps      = lamps_of(r_state);
    if (w_tick) begin
      case (r_state)
        GREEN: begin
          if (w_alert_s || w_expired) w_state_next = YELLOW;
        end
        RED: begin
          if (w_alert_s)      w_state_next = YELLOW;
          else if (w_expired) w_state_next = GREEN;
        end
        YELLOW: begin
          if (w_expired) w_state_next = w_alert_s ? OFF : RED;
        end
        default: begin
          // OFF only blinks back while alert holds; otherwise it locks.
          if (w_alert_s && w_expired) w_state_next = YELLOW;
        end
      endcase
    end
    if (w_state_next != r_state) begin
      w_dwell_next = '0;
    end else if (w_tick) begin
      w_dwell_next = r_dwell + DWELL_W'(1);
    end
  end

  assign bus.state  = r_state;
  assign bus.lamp_g = w_lamps[2];
  assign bus.lamp_y = w_lamps[1];
  assign bus.lamp_r = w_lamps[0];
  assign bus.tick   = w_tick;

endmodule

// File: tb/tb_traffic_seq.sv
// Bench for traffic_seq: timeline vector table with a scoreboard queue,
// plus hand sequences for async reset, OFF lock and the TICK_DIV=1 variant.
module tb_traffic_seq;
  import traffic_pkg::*;

  logic clk;
  logic reset;

  traffic_seq_if dut_if();
  traffic_seq_if fast_if();

  traffic_seq #(
    .TICK_DIV(4), .T_GREEN(3), .T_YELLOW(2), .T_RED(3), .T_BLINK(1)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if)
  );

  traffic_seq #(
    .TICK_DIV(1), .T_GREEN(3), .T_YELLOW(2), .T_RED(3), .T_BLINK(1)
  ) u_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (fast_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit           rst_first;
    int           n;
    logic         alert;
    light_state_e st;
    int           post;
    string        name;
  } vec_t;

  typedef struct {
    light_state_e st;
    logic         tk;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [2:0] exp_lamps(input light_state_e st);
    case (st)
      GREEN:   return 3'b100;
      YELLOW:  return 3'b010;
      RED:     return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic pop_check(input string name, input int k, input logic [1:0] g_st,
                           input logic [2:0] g_lamps, input logic g_tk);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s cyc=%0d scoreboard empty", name, k);
      return;
    end
    e = sb.pop_front();
    n_tests++;
    if ({g_st, g_lamps, g_tk} !== {e.st, exp_lamps(e.st), e.tk}) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got state=%b lamps(gyr)=%b tick=%b want state=%b lamps(gyr)=%b tick=%b",
               name, k, g_st, g_lamps, g_tk, e.st, exp_lamps(e.st), e.tk);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic run_cycle(input string name, input int k, input logic a, input light_state_e st);
    dut_if.alert = a;
    sb.push_back('{st, logic'((k % 4) == 3)});
    #1;
    pop_check(name, k, dut_if.state, {dut_if.lamp_g, dut_if.lamp_y, dut_if.lamp_r}, dut_if.tick);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    dut_if.alert = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reset asserted between edges must take effect before the next clock,
  // then the first tick must come at cycle 3 (consumed by the 4th edge).
  task automatic async_reset_check(input string name);
    int first_tick;
    #2;
    reset = 1'b1;
    #1;
    sb.push_back('{GREEN, 1'b0});
    pop_check({name, "_async"}, -1, dut_if.state,
              {dut_if.lamp_g, dut_if.lamp_y, dut_if.lamp_r}, dut_if.tick);
    @(negedge clk);
    reset      = 1'b0;
    first_tick = -1;
    for (int k = 0; k < 10 && first_tick < 0; k++) begin
      #1;
      if (dut_if.tick === 1'b1) first_tick = k;
      @(negedge clk);
    end
    n_tests++;
    if (first_tick != 3) begin
      n_fail++;
      $display("FAIL %s_first_tick got cyc=%0d want cyc=3", name, first_tick);
    end
    $display("[TB] %s: async reset and tick restart checked", name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset         = 1'b1;
    dut_if.alert  = 1'b0;
    fast_if.alert = 1'b0;

    // Normal cycle
    vecs.push_back('{1, 12, 1'b0, GREEN,  0, "norm_green"});
    vecs.push_back('{0,  8, 1'b0, YELLOW, 0, "norm_yellow"});
    vecs.push_back('{0, 12, 1'b0, RED,    0, "norm_red"});
    vecs.push_back('{0, 12, 1'b0, GREEN,  0, "norm_green2"});
    vecs.push_back('{0,  8, 1'b0, YELLOW, 0, "norm_yellow2"});
    // Forced alert, blink, then release from YELLOW
    vecs.push_back('{1,  5, 1'b0, GREEN,  0, "alrt_pre"});
    vecs.push_back('{0,  3, 1'b1, GREEN,  0, "alrt_sync"});
    vecs.push_back('{0,  4, 1'b1, YELLOW, 0, "alrt_yel"});
    vecs.push_back('{0,  4, 1'b1, OFF,    0, "alrt_off"});
    vecs.push_back('{0,  4, 1'b1, YELLOW, 0, "alrt_yel2"});
    vecs.push_back('{0,  4, 1'b1, OFF,    0, "alrt_off2"});
    vecs.push_back('{0,  1, 1'b1, YELLOW, 0, "alrt_yel3"});
    vecs.push_back('{0,  7, 1'b0, YELLOW, 0, "rel_yel"});
    vecs.push_back('{0, 12, 1'b0, RED,    0, "rel_red"});
    vecs.push_back('{0, 12, 1'b0, GREEN,  0, "rel_green"});
    vecs.push_back('{0,  8, 1'b0, YELLOW, 0, "rel_yellow"});
    // OFF lock, then reset pulse
    vecs.push_back('{1,  5, 1'b0, GREEN,  0, "lock_pre"});
    vecs.push_back('{0,  3, 1'b1, GREEN,  0, "lock_sync"});
    vecs.push_back('{0,  4, 1'b1, YELLOW, 0, "lock_yel"});
    vecs.push_back('{0,  1, 1'b1, OFF,    0, "lock_off"});
    vecs.push_back('{0, 200, 1'b0, OFF,   1, "lock_hold"});
    // Asynchronous reset mid-RED
    vecs.push_back('{1, 12, 1'b0, GREEN,  0, "mid_green"});
    vecs.push_back('{0,  8, 1'b0, YELLOW, 0, "mid_yellow"});
    vecs.push_back('{0,  6, 1'b0, RED,    2, "mid_red"});

    k = 0;
    foreach (vecs[i]) begin
      if (vecs[i].rst_first) begin
        do_reset();
        k = 0;
      end
      for (int c = 0; c < vecs[i].n; c++) begin
        run_cycle(vecs[i].name, k, vecs[i].alert, vecs[i].st);
        k++;
      end
      $display("[TB] vector %s: %0d cycles state=%s alert=%b", vecs[i].name,
               vecs[i].n, vecs[i].st.name(), vecs[i].alert);
      if (vecs[i].post == 1) async_reset_check("lock_reset");
      if (vecs[i].post == 2) async_reset_check("mid_reset");
    end

    // Constant tick: TICK_DIV=1 gives GREEN 3, YELLOW 2, RED 3 cycles
    do_reset();
    for (int c = 0; c < 17; c++) begin
      light_state_e st;
      st = ((c % 8) < 3) ? GREEN : (((c % 8) < 5) ? YELLOW : RED);
      sb.push_back('{st, 1'b1});
      #1;
      pop_check("const_tick", c, fast_if.state,
                {fast_if.lamp_g, fast_if.lamp_y, fast_if.lamp_r}, fast_if.tick);
      @(negedge clk);
    end
    $display("[TB] const_tick: 17 cycles checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
